// File: rtl/alu_writeback.sv
// Write-back stage behind the 6502 ALU.
// Captures each result, applies the decimal (BCD) adjust when needed, hands the result off on a valid/ready
// handshake, and then merges the flags into P.
//
// state  | meaning
// IDLE   | waiting for a rising edge on alu_wout
// ADJUST | one cycle of decimal correction on a captured SUM
// HOLD   | result presented, waiting for wb_ready
module alu_writeback #(
    parameter int REG_WIDTH = 8,
    parameter int OPP_WIDTH = 4,
    parameter logic [OPP_WIDTH-1:0] FUNC_SUM = OPP_WIDTH'(1)
) (
    input  logic                 phi1,
    input  logic                 reset,
    input  logic [REG_WIDTH-1:0] alu_dout,
    input  logic [REG_WIDTH-1:0] alu_status,
    input  logic                 alu_wout,
    input  logic [REG_WIDTH-1:0] alu_a,
    input  logic [REG_WIDTH-1:0] alu_b,
    input  logic                 carry_in,
    input  logic [OPP_WIDTH-1:0] func,
    input  logic                 dec_mode,
    input  logic                 sub_mode,
    input  logic [1:0]           dest_sel,
    input  logic [REG_WIDTH-1:0] flag_mask,
    input  logic [REG_WIDTH-1:0] p_in,
    output logic [REG_WIDTH-1:0] wb_data,
    output logic [1:0]           wb_dest,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [REG_WIDTH-1:0] p_out,
    output logic                 p_we,
    output logic                 busy,
    output logic                 overrun
);

    localparam int BIT_C = 0;
    localparam int BIT_Z = 1;
    localparam int BIT_B = 4;
    localparam int BIT_U = 5;
    localparam int BIT_N = 7;
    localparam logic [REG_WIDTH-1:0] ADJ_LO = REG_WIDTH'(8'h06);
    localparam logic [REG_WIDTH-1:0] ADJ_HI = REG_WIDTH'(8'h60);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADJUST = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                 wout_d;
    logic                 wout_rise;
    logic                 capture;
    logic                 take;
    logic [REG_WIDTH-1:0] a_q, b_q, flags_q, mask_q;
    logic                 cin_q, sub_q;
    logic [REG_WIDTH-1:0] sum_full;
    logic                 hc;
    logic [REG_WIDTH-1:0] adj1, adj2;
    logic                 adj_c;
    logic [REG_WIDTH-1:0] p_merge;

    assign wout_rise = alu_wout & ~wout_d;
    assign capture   = wout_rise & (state == S_IDLE);
    assign take      = wb_valid & wb_ready & (state == S_HOLD);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge phi1) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (capture) state_nxt = (func == FUNC_SUM && dec_mode) ? S_ADJUST : S_HOLD;
            S_ADJUST: state_nxt = S_HOLD;
            S_HOLD:   if (take) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Half carry is the carry into bit 4, recovered from the full operand sum.
    assign sum_full = a_q + b_q + REG_WIDTH'(cin_q);
    assign hc       = a_q[4] ^ b_q[4] ^ sum_full[4];

    always_comb begin
        adj1  = wb_data;
        adj2  = wb_data;
        adj_c = flags_q[BIT_C];
        if (!sub_q) begin
            if (wb_data[3:0] > 4'd9 || hc) adj1 = wb_data + ADJ_LO;
            adj2 = adj1;
            if (adj1[7:4] > 4'd9 || flags_q[BIT_C]) begin
                adj2  = adj1 + ADJ_HI;
                adj_c = 1'b1;
            end
        end else begin
            if (!hc) adj1 = wb_data - ADJ_LO;
            adj2 = adj1;
            if (!flags_q[BIT_C]) adj2 = adj1 - ADJ_HI;
        end
    end

    always_comb begin
        p_merge        = (p_in & ~mask_q) | (flags_q & mask_q);
        p_merge[BIT_U] = 1'b1;
        p_merge[BIT_B] = p_in[BIT_B];
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            wout_d   <= 1'b1;
            wb_data  <= '0;
            wb_dest  <= '0;
            wb_valid <= 1'b0;
            p_out    <= '0;
            p_we     <= 1'b0;
            overrun  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            sub_q    <= 1'b0;
            flags_q  <= '0;
            mask_q   <= '0;
        end else begin
            wout_d <= alu_wout;
            p_we   <= take;
            if (wout_rise && state != S_IDLE) overrun <= 1'b1;
            if (capture) begin
                wb_data  <= alu_dout;
                wb_dest  <= dest_sel;
                flags_q  <= alu_status;
                mask_q   <= flag_mask;
                a_q      <= alu_a;
                b_q      <= alu_b;
                cin_q    <= carry_in;
                sub_q    <= sub_mode;
                wb_valid <= !(func == FUNC_SUM && dec_mode);
            end
            if (state == S_ADJUST) begin
                wb_data        <= adj2;
                flags_q[BIT_C] <= adj_c;
                flags_q[BIT_Z] <= (adj2 == '0);
                flags_q[BIT_N] <= adj2[BIT_N];
                wb_valid       <= 1'b1;
            end
            if (take) begin
                wb_valid <= 1'b0;
                p_out    <= p_merge;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: binary and decimal results, handshake stall, overrun and reset.
module tb_alu_writeback;

    localparam logic [3:0] F_SUM = 4'd1;
    localparam logic [3:0] F_AND = 4'd5;

    logic       phi1 = 1'b0;
    logic       reset;
    logic [7:0] alu_dout, alu_status, alu_a, alu_b, flag_mask, p_in;
    logic       alu_wout, carry_in, dec_mode, sub_mode, wb_ready;
    logic [3:0] func;
    logic [1:0] dest_sel;
    logic [7:0] wb_data, p_out;
    logic [1:0] wb_dest;
    logic       wb_valid, p_we, busy, overrun;

    int n_total = 0;
    int n_bad   = 0;

    alu_writeback #(.REG_WIDTH(8), .OPP_WIDTH(4), .FUNC_SUM(F_SUM)) dut (
        .phi1(phi1), .reset(reset), .alu_dout(alu_dout), .alu_status(alu_status),
        .alu_wout(alu_wout), .alu_a(alu_a), .alu_b(alu_b), .carry_in(carry_in),
        .func(func), .dec_mode(dec_mode), .sub_mode(sub_mode), .dest_sel(dest_sel),
        .flag_mask(flag_mask), .p_in(p_in), .wb_data(wb_data), .wb_dest(wb_dest),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .p_out(p_out), .p_we(p_we),
        .busy(busy), .overrun(overrun)
    );

    always #5 phi1 = ~phi1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    // Presents one ALU result with a rising alu_wout; returns just after the capture edge.
    task automatic issue(input logic [3:0] f, input logic dec, input logic sub,
                         input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] dout, input logic [7:0] st, input logic [1:0] dst,
                         input logic [7:0] mask);
        func = f; dec_mode = dec; sub_mode = sub;
        alu_a = a; alu_b = b; carry_in = cin;
        alu_dout = dout; alu_status = st; dest_sel = dst; flag_mask = mask;
        alu_wout = 1'b1;
        tick();
    endtask

    task automatic drain(input logic [7:0] p_exp, input string tag);
        wb_ready = 1'b1;
        tick();
        check({tag, "_pwe"},   16'(p_we), 16'h1);
        check({tag, "_pout"},  16'(p_out), 16'(p_exp));
        check({tag, "_vdrop"}, 16'(wb_valid), 16'h0);
        check({tag, "_idle"},  16'(busy), 16'h0);
        wb_ready = 1'b0;
        tick();
        check({tag, "_pwe1"},  16'(p_we), 16'h0);
    endtask

    initial begin
        reset = 1'b1; alu_wout = 1'b0; wb_ready = 1'b0;
        alu_dout = '0; alu_status = '0; alu_a = '0; alu_b = '0; carry_in = 1'b0;
        func = '0; dec_mode = 1'b0; sub_mode = 1'b0; dest_sel = '0; flag_mask = '0; p_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_data",  16'(wb_data), 16'h0);
        check("rst_dest",  16'(wb_dest), 16'h0);
        check("rst_valid", 16'(wb_valid), 16'h0);
        check("rst_pout",  16'(p_out), 16'h0);
        check("rst_pwe",   16'(p_we), 16'h0);
        check("rst_busy",  16'(busy), 16'h0);
        check("rst_ovr",   16'(overrun), 16'h0);

        // 1: binary result, valid right after the capture edge
        p_in = 8'h24;
        issue(F_AND, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h03, 2'b01, 8'hC3);
        alu_wout = 1'b0;
        check("bin_valid", 16'(wb_valid), 16'h1);
        check("bin_data",  16'(wb_data), 16'h00);
        check("bin_dest",  16'(wb_dest), 16'h1);
        check("bin_busy",  16'(busy), 16'h1);
        drain(8'h27, "bin");

        // 2: BCD add 15+27
        issue(F_SUM, 1'b1, 1'b0, 8'h15, 8'h27, 1'b0, 8'h3C, 8'h00, 2'b00, 8'hC3);
        alu_wout = 1'b0;
        check("bcd_lat1", 16'(wb_valid), 16'h0);
        check("bcd_busy", 16'(busy), 16'h1);
        tick();
        check("bcd_lat2", 16'(wb_valid), 16'h1);
        check("bcd_data", 16'(wb_data), 16'h42);
        drain(8'h24, "bcd");

        // 3: BCD add 99+01 wraps to 00 with carry
        issue(F_SUM, 1'b1, 1'b0, 8'h99, 8'h01, 1'b0, 8'h9A, 8'h80, 2'b00, 8'hC3);
        alu_wout = 1'b0;
        tick();
        check("wrap_data", 16'(wb_data), 16'h00);
        drain(8'h27, "wrap");

        // 4: BCD subtract 42-15 (b already inverted)
        p_in = 8'hE4;
        issue(F_SUM, 1'b1, 1'b1, 8'h42, 8'hEA, 1'b1, 8'h2D, 8'h01, 2'b10, 8'hC3);
        alu_wout = 1'b0;
        tick();
        check("sub_data", 16'(wb_data), 16'h27);
        check("sub_dest", 16'(wb_dest), 16'h2);
        drain(8'h25, "sub");

        // 5: stall for 5 cycles with a second wout rise; full mask keeps B from p_in
        p_in = 8'h10;
        issue(F_AND, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h5A, 8'h00, 2'b11, 8'hFF);
        alu_wout = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) alu_wout = 1'b1;
            tick();
            check("stall_data", 16'(wb_data), 16'h5A);
            check("stall_dest", 16'(wb_dest), 16'h3);
            check("stall_pwe",  16'(p_we), 16'h0);
            check("stall_vld",  16'(wb_valid), 16'h1);
        end
        check("ovr_set", 16'(overrun), 16'h1);
        alu_wout = 1'b0;
        drain(8'h30, "stall");
        check("ovr_sticky", 16'(overrun), 16'h1);

        // 6: reset during ADJUST with alu_wout held high through release
        issue(F_SUM, 1'b1, 1'b0, 8'h15, 8'h27, 1'b0, 8'h3C, 8'h00, 2'b01, 8'hC3);
        check("adj_busy", 16'(busy), 16'h1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rr_busy",  16'(busy), 16'h0);
            check("rr_valid", 16'(wb_valid), 16'h0);
            check("rr_pwe",   16'(p_we), 16'h0);
        end
        check("rr_data", 16'(wb_data), 16'h00);
        check("rr_dest", 16'(wb_dest), 16'h0);
        check("rr_pout", 16'(p_out), 16'h00);
        check("rr_ovr",  16'(overrun), 16'h0);
        wb_ready = 1'b0;

        // a fresh fall/rise after reset is captured again
        alu_wout = 1'b0;
        tick();
        p_in = 8'h24;
        issue(F_AND, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h81, 8'h80, 2'b10, 8'hC3);
        alu_wout = 1'b0;
        check("again_valid", 16'(wb_valid), 16'h1);
        check("again_data",  16'(wb_data), 16'h81);
        drain(8'hA4, "again");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
